// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
// master = the decode stage (producer of ALU ops), slave = its environment.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [3:0]      out_alu_func;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_a_pc;
    logic            out_b_imm;
    logic            out_reg_we;
    logic            out_illegal;

    modport master (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_alu_func, out_rs1, out_rs2,
               out_rd, out_imm, out_a_pc, out_b_imm, out_reg_we, out_illegal
    );

    modport slave (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_func, out_rs1, out_rs2,
               out_rd, out_imm, out_a_pc, out_b_imm, out_reg_we, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word, registered into a
// 2-entry skid buffer (main + skid) so in_ready is a flop and throughput is 1/cycle.
module decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           flush_in,
    decode_stage_if.master bus
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      func;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            a_pc;
        logic            b_imm;
        logic            reg_we;
        logic            illegal;
    } beat_t;

    function automatic logic [3:0] f3_func(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_func = ALU_ADD;
            3'b001:  f3_func = ALU_SLL;
            3'b010:  f3_func = ALU_SLT;
            3'b011:  f3_func = ALU_SLTU;
            3'b100:  f3_func = ALU_XOR;
            3'b101:  f3_func = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_func = ALU_OR;
            default: f3_func = ALU_AND;
        endcase
    endfunction

    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    logic        writes;
    beat_t       dec;

    assign instr = bus.in_instr;
    assign op    = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        dec.pc     = bus.in_pc;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        legal      = 1'b1;
        writes     = 1'b0;
        case (op)
            OPC_OP: begin
                dec.rs2  = instr[24:20];
                dec.func = (f3 == 3'b000 && f7[5]) ? ALU_SUB : f3_func(f3, f7[5]);
                legal    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                writes   = 1'b1;
            end
            OPC_OPIMM: begin
                dec.func  = f3_func(f3, f7[5]);
                dec.imm   = imm_i;
                dec.b_imm = 1'b1;
                writes    = 1'b1;
                if (f3 == 3'b001)
                    legal = (f7 == 7'h00);
                else if (f3 == 3'b101)
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
            end
            OPC_LUI: begin
                dec.rs1   = '0;
                dec.imm   = imm_u;
                dec.b_imm = 1'b1;
                writes    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm   = imm_u;
                dec.a_pc  = 1'b1;
                dec.b_imm = 1'b1;
                writes    = 1'b1;
            end
            OPC_JAL: begin
                dec.rs1   = '0;
                dec.imm   = imm_j;
                dec.a_pc  = 1'b1;
                dec.b_imm = 1'b1;
                writes    = 1'b1;
            end
            OPC_JALR: begin
                dec.imm   = imm_i;
                dec.b_imm = 1'b1;
                writes    = 1'b1;
                legal     = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec.rs2 = instr[24:20];
                dec.imm = imm_b;
                case (f3[2:1])
                    2'b00:   dec.func = ALU_SUB;
                    2'b10:   dec.func = ALU_SLT;
                    2'b11:   dec.func = ALU_SLTU;
                    default: legal    = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.imm   = imm_i;
                dec.b_imm = 1'b1;
                writes    = 1'b1;
                legal     = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            OPC_STORE: begin
                dec.rs2   = instr[24:20];
                dec.imm   = imm_s;
                dec.b_imm = 1'b1;
                legal     = (f3 <= 3'b010);
            end
            default: legal = 1'b0;
        endcase
        // Illegal beats still travel down the pipe, but carry no side effects.
        if (!legal) begin
            dec.func  = ALU_ADD;
            dec.imm   = '0;
            dec.a_pc  = 1'b0;
            dec.b_imm = 1'b0;
        end
        dec.illegal = !legal;
        dec.reg_we  = writes && legal && (dec.rd != 5'd0);
    end

    logic [1:0] state_q, state_d;
    beat_t      main_q, main_d;
    beat_t      skid_q, skid_d;
    logic       in_ready_q;
    logic       accept;
    logic       emit;

    assign accept = bus.in_valid && in_ready_q;
    assign emit   = (state_q != S_EMPTY) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_in) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && emit) begin
                        main_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = S_FULL;
                    end else if (emit) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (emit) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = (state_q != S_EMPTY);
    assign bus.out_pc       = main_q.pc;
    assign bus.out_alu_func = main_q.func;
    assign bus.out_rs1      = main_q.rs1;
    assign bus.out_rs2      = main_q.rs2;
    assign bus.out_rd       = main_q.rd;
    assign bus.out_imm      = main_q.imm;
    assign bus.out_a_pc     = main_q.a_pc;
    assign bus.out_b_imm    = main_q.b_imm;
    assign bus.out_reg_we   = main_q.reg_we;
    assign bus.out_illegal  = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: queue-based reference model of the stage,
// directed literal checks, then a randomized stream with random backpressure/flush.
module tb_decode_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  func;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        a_pc;
        logic        b_imm;
        logic        reg_we;
        logic        illegal;
    } beat_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_chk;
    int   n_fail;

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .flush_in (flush),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU code by funct3 for the arithmetic opcodes, and by funct3 for branches
    int alu_lut [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    int br_lut  [8] = '{1, 1, 0, 0, 5, 5, 6, 6};

    function automatic beat_t ref_decode(input logic [31:0] pc, input logic [31:0] w);
        beat_t      b;
        logic [6:0] f7;
        int         f3;
        bit         ok;
        bit         writes;
        b      = '0;
        f7     = w[31:25];
        f3     = int'(w[14:12]);
        ok     = 1'b1;
        writes = 1'b1;
        b.pc   = pc;
        b.rd   = w[11:7];
        b.rs1  = w[19:15];
        case (w[6:0])
            7'h33: begin
                b.rs2  = w[24:20];
                ok     = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                b.func = 4'(alu_lut[f3]);
                if (f3 == 5 && f7[5]) b.func = 4'd9;
                if (f3 == 0 && f7[5]) b.func = 4'd1;
            end
            7'h13: begin
                ok      = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                b.func  = 4'(alu_lut[f3]);
                if (f3 == 5 && f7[5]) b.func = 4'd9;
                b.imm   = 32'($signed(w) >>> 20);
                b.b_imm = 1'b1;
            end
            7'h37: begin b.rs1 = 0; b.imm = w & 32'hFFFF_F000; b.b_imm = 1; end
            7'h17: begin b.imm = w & 32'hFFFF_F000; b.a_pc = 1; b.b_imm = 1; end
            7'h6F: begin
                b.rs1 = 0; b.a_pc = 1; b.b_imm = 1;
                b.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h67: begin ok = (f3 == 0); b.imm = 32'($signed(w) >>> 20); b.b_imm = 1; end
            7'h63: begin
                writes = 0; b.rs2 = w[24:20];
                ok     = (f3 != 2) && (f3 != 3);
                b.func = 4'(br_lut[f3]);
                b.imm  = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h03: begin ok = (8'b0011_0111 >> f3) & 1; b.imm = 32'($signed(w) >>> 20); b.b_imm = 1; end
            7'h23: begin
                writes = 0; ok = (f3 <= 2); b.rs2 = w[24:20]; b.b_imm = 1;
                b.imm  = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            b.func = 0; b.imm = 0; b.a_pc = 0; b.b_imm = 0;
        end
        b.illegal = !ok;
        b.reg_we  = writes && ok && (b.rd != 0);
        return b;
    endfunction

    function automatic logic [31:0] gen_legal();
        logic [31:0] w;
        bit          coin;
        w    = $urandom;
        coin = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 8))
            0: begin
                w[6:0]   = 7'h33;
                w[31:25] = ((w[14:12] == 3'd0 || w[14:12] == 3'd5) && coin) ? 7'h20 : 7'h00;
            end
            1: begin
                w[6:0] = 7'h13;
                if (w[14:12] == 3'd1) w[31:25] = 7'h00;
                if (w[14:12] == 3'd5) w[31:25] = coin ? 7'h20 : 7'h00;
            end
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h6F;
            5: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
            6: begin w[6:0] = 7'h63; if (w[14:13] == 2'b01) w[14] = 1'b1; end
            7: begin
                w[6:0] = 7'h03;
                if (w[14:12] == 3'd3 || w[14:12] >= 3'd6) w[14:12] = 3'd2;
            end
            default: begin
                w[6:0] = 7'h23; w[14] = 1'b0;
                if (w[13:12] == 2'b11) w[13] = 1'b0;
            end
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    beat_t q[$];
    bit    m_acc;
    bit    m_emit;
    beat_t act_beat;

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            m_acc  = bus.in_valid && (q.size() < 2);
            m_emit = (q.size() > 0) && bus.out_ready;
            if (m_emit) void'(q.pop_front());
            if (m_acc) q.push_back(ref_decode(bus.in_pc, bus.in_instr));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                act_beat = '{bus.out_pc, bus.out_alu_func, bus.out_rs1, bus.out_rs2, bus.out_rd,
                             bus.out_imm, bus.out_a_pc, bus.out_b_imm, bus.out_reg_we,
                             bus.out_illegal};
                n_chk++;
                if (act_beat !== q[0]) begin
                    n_fail++;
                    $display("FAIL out_beat: got %h expected %h at %0t", act_beat, q[0], $time);
                end
            end
        end
    end

    task automatic offer(input logic [31:0] pc, input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = w;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = w;
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_out_imm", bus.out_imm, 0);
        chk("rst_out_rd", 32'(bus.out_rd), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        offer(32'h100, 32'h002081B3);
        chk("add_valid", 32'(bus.out_valid), 1);
        chk("add_func", 32'(bus.out_alu_func), 0);
        chk("add_rs1", 32'(bus.out_rs1), 1);
        chk("add_rs2", 32'(bus.out_rs2), 2);
        chk("add_rd", 32'(bus.out_rd), 3);
        chk("add_we", 32'(bus.out_reg_we), 1);
        chk("add_bimm", 32'(bus.out_b_imm), 0);
        chk("add_pc", bus.out_pc, 32'h100);

        offer(32'h104, 32'h402081B3);
        chk("sub_func", 32'(bus.out_alu_func), 1);

        offer(32'h108, 32'h40335293);
        chk("srai_func", 32'(bus.out_alu_func), 9);
        chk("srai_imm", bus.out_imm, 32'h0000_0403);
        chk("srai_bimm", 32'(bus.out_b_imm), 1);
        chk("srai_rd", 32'(bus.out_rd), 5);

        offer(32'h10C, 32'hFFF00093);
        chk("addi_imm", bus.out_imm, 32'hFFFF_FFFF);

        offer(32'h110, 32'h123453B7);
        chk("lui_imm", bus.out_imm, 32'h1234_5000);
        chk("lui_rs1", 32'(bus.out_rs1), 0);
        chk("lui_rd", 32'(bus.out_rd), 7);

        offer(32'h114, 32'h00000000);
        chk("zero_illegal", 32'(bus.out_illegal), 1);
        chk("zero_we", 32'(bus.out_reg_we), 0);

        offer(32'h118, 32'h0220C1B3);
        chk("f7_illegal", 32'(bus.out_illegal), 1);
        chk("f7_we", 32'(bus.out_reg_we), 0);
        chk("f7_func", 32'(bus.out_alu_func), 0);

        // Backpressure: third beat must be refused while both entries are occupied.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(32'h200, 32'h00108093);
        @(posedge clk); #1;
        drive(32'h204, 32'h00210113);
        @(posedge clk); #1;
        drive(32'h208, 32'h00318193);
        @(negedge clk);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_head", bus.out_pc, 32'h200);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("stall_head", bus.out_pc, 32'h200);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_1", bus.out_pc, 32'h204);
        chk("drain_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("drain_2", bus.out_pc, 32'h208);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drained", 32'(bus.out_valid), 0);

        // Flush from FULL with a beat offered in the same cycle.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(32'h300, 32'h00500293);
        @(posedge clk); #1;
        drive(32'h304, 32'h00600313);
        @(posedge clk); #1;
        drive(32'h308, 32'h00700393);
        flush = 1'b1;
        @(negedge clk);
        chk("pre_flush_ready", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_dropped", 32'(bus.out_valid), 0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = $urandom_range(0, 9) < 7;
            bus.out_ready = $urandom_range(0, 9) < 6;
            flush         = $urandom_range(0, 63) == 0;
            bus.in_pc     = 32'h1000 + 32'(i) * 4;
            bus.in_instr  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : gen_legal();
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
